// File: rtl/sobel_window_ctrl.sv
// Raster-scan control for a 3x3 Sobel window fed by two line delays.
// Optional mid-frame resync on sof_in: define SOF_RESYNC_EN.
module sobel_window_ctrl #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int XW           = $clog2(LINE_WIDTH),
  parameter int YW           = $clog2(FRAME_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid_in,
  input  logic          sof_in,
  output logic          line_en,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          eof,
  output logic          busy
`ifdef SOF_RESYNC_EN
  ,
  output logic          frame_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [XW-1:0] XLAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] YLAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [XW-1:0] XTWO  = XW'(2);
  localparam logic [YW-1:0] YTWO  = YW'(2);
  localparam logic [XW-1:0] XONE  = XW'(1);
  localparam logic [YW-1:0] YONE  = YW'(1);

  state_t        state_q, state_d;
  logic [XW-1:0] in_x_q, in_x_d;
  logic [YW-1:0] in_y_q, in_y_d;
  logic          win_valid_q, win_valid_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
  logic          eof_q, eof_d;
  logic          accept;
  logic          x_last;
  logic          y_last;
  logic          last_pix;
  logic          resync_hit;
`ifdef SOF_RESYNC_EN
  logic          ferr_q, ferr_d;
`endif

  assign x_last   = (in_x_q == XLAST);
  assign y_last   = (in_y_q == YLAST);
  assign last_pix = x_last & y_last;

  // A start-of-frame on the final pixel never restarts the frame;
  // the next frame has to begin from IDLE.
`ifdef SOF_RESYNC_EN
  assign resync_hit = sof_in & ~last_pix;
`else
  assign resync_hit = 1'b0;
`endif

  // Next-state: frame position tracking and window qualification.
  always_comb begin
    state_d     = state_q;
    in_x_d      = in_x_q;
    in_y_d      = in_y_q;
    win_valid_d = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    eof_d       = 1'b0;
    accept      = 1'b0;
`ifdef SOF_RESYNC_EN
    ferr_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pix_valid_in && sof_in) begin
          accept  = 1'b1;
          state_d = FILL;
          in_x_d  = XONE;
          in_y_d  = '0;
        end
      end
      FILL, RUN: begin
        if (pix_valid_in) begin
          accept = 1'b1;
          if (resync_hit) begin
            state_d = FILL;
            in_x_d  = XONE;
            in_y_d  = '0;
`ifdef SOF_RESYNC_EN
            ferr_d  = 1'b1;
`endif
          end else begin
            if (in_x_q >= XTWO && in_y_q >= YTWO) begin
              win_valid_d = 1'b1;
              win_x_d     = in_x_q - XONE;
              win_y_d     = in_y_q - YONE;
            end
            if (x_last) begin
              in_x_d = '0;
              if (y_last) begin
                in_y_d  = '0;
                state_d = IDLE;
                eof_d   = 1'b1;
              end else begin
                in_y_d = in_y_q + YONE;
                if (in_y_q == YONE) begin
                  state_d = RUN;
                end
              end
            end else begin
              in_x_d = in_x_q + XONE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        in_x_d  = '0;
        in_y_d  = '0;
      end
    endcase
  end

  // State, counters and registered window outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_x_q      <= '0;
      in_y_q      <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      eof_q       <= 1'b0;
`ifdef SOF_RESYNC_EN
      ferr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      eof_q       <= eof_d;
`ifdef SOF_RESYNC_EN
      ferr_q      <= ferr_d;
`endif
    end
  end

  assign line_en   = rst & accept;
  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign eof       = eof_q;
  assign busy      = (state_q != IDLE);
`ifdef SOF_RESYNC_EN
  assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 10x5 frame.
// Define SOF_RESYNC_EN to exercise the resync build.
module tb_sobel_window_ctrl;
  localparam int LW = 10;
  localparam int FH = 5;
  localparam int XW = $clog2(LW);
  localparam int YW = $clog2(FH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_valid_in = 1'b0;
  logic          sof_in = 1'b0;
  logic          line_en;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          eof;
  logic          busy;
`ifdef SOF_RESYNC_EN
  logic          frame_err;
`endif

  sobel_window_ctrl #(
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid_in(pix_valid_in),
    .sof_in      (sof_in),
    .line_en     (line_en),
    .win_valid   (win_valid),
    .win_x       (win_x),
    .win_y       (win_y),
    .eof         (eof),
    .busy        (busy)
`ifdef SOF_RESYNC_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit e;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nmis = 0;
  int win_cnt = 0;
  int eof_cnt = 0;
  int ferr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_win(input int x, input int y, input bit e);
    exp_t t;
    t.x = x;
    t.y = y;
    t.e = e;
    sb.push_back(t);
  endfunction

  function automatic void push_frame();
    for (int y = 1; y <= FH - 2; y++)
      for (int x = 1; x <= LW - 2; x++)
        push_win(x, y, (x == LW - 2) && (y == FH - 2));
  endfunction

  // Monitor: every presented window is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (win_valid) begin
      win_cnt++;
      chk("sb_has_entry", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("win_x", int'(win_x), e.x);
        chk("win_y", int'(win_y), e.y);
        chk("win_eof", int'(eof), int'(e.e));
      end
    end
    if (eof) begin
      eof_cnt++;
      chk("eof_with_win", int'(win_valid), 1);
    end
`ifdef SOF_RESYNC_EN
    if (frame_err) ferr_cnt++;
`endif
  end

  task automatic pix(input bit v, input bit s, input bit r);
    @(posedge clk);
    #1;
    pix_valid_in = v;
    sof_in = s;
    rst = r;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input int n, input bit gaps, input int sof_idx,
                      output int le, output int first, output int b2b);
    int k;
    bit prev;
    k = 0;
    prev = 1'b0;
    le = 0;
    first = -1;
    b2b = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < (gaps ? 2 : 1); g++) begin
        if (g == 0) pix(1'b1, (i == 0) || (i == sof_idx), 1'b1);
        else pix(1'b0, 1'b0, 1'b1);
        if (line_en) le++;
        if (win_valid && first < 0) first = k;
        if (win_valid && prev) b2b++;
        prev = win_valid;
        k++;
      end
    end
  endtask

  int le, first, b2b, w0, e0, f0;

  initial begin
    // reset: outputs cleared, line_en blocked
    pix(1'b1, 1'b1, 1'b0);
    chk("le_in_reset", int'(line_en), 0);
    pix(1'b0, 1'b0, 1'b0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_win_x", int'(win_x), 0);
    chk("rst_win_y", int'(win_y), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_busy", int'(busy), 0);
    idle(2);

    // continuous frame
    push_frame();
    w0 = win_cnt;
    e0 = eof_cnt;
    send(LW * FH, 1'b0, -1, le, first, b2b);
    chk("t1_busy", int'(busy), 1);
    idle(3);
    chk("t1_line_en", le, 50);
    chk("t1_first_lat", first, 23);
    chk("t1_wins", win_cnt - w0, 24);
    chk("t1_eofs", eof_cnt - e0, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_idle_busy", int'(busy), 0);

    // gapped frame
    push_frame();
    w0 = win_cnt;
    e0 = eof_cnt;
    send(LW * FH, 1'b1, -1, le, first, b2b);
    idle(3);
    chk("t2_line_en", le, 50);
    chk("t2_wins", win_cnt - w0, 24);
    chk("t2_b2b", b2b, 0);
    chk("t2_eofs", eof_cnt - e0, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // pixels without sof in IDLE are dropped
    w0 = win_cnt;
    for (int i = 0; i < 4; i++) begin
      pix(1'b1, 1'b0, 1'b1);
      chk("t3_line_en", int'(line_en), 0);
      chk("t3_busy", int'(busy), 0);
    end
    idle(2);
    chk("t3_wins", win_cnt - w0, 0);

    // reset at pixel (5,3)
    for (int x = 1; x <= 8; x++) push_win(x, 1, 1'b0);
    for (int x = 1; x <= 3; x++) push_win(x, 2, 1'b0);
    w0 = win_cnt;
    e0 = eof_cnt;
    send(35, 1'b0, -1, le, first, b2b);
    pix(1'b1, 1'b0, 1'b0);
    chk("t4_le_rst", int'(line_en), 0);
    pix(1'b0, 1'b0, 1'b1);
    chk("t4_win_valid", int'(win_valid), 0);
    chk("t4_win_x", int'(win_x), 0);
    chk("t4_win_y", int'(win_y), 0);
    chk("t4_eof", int'(eof), 0);
    chk("t4_busy", int'(busy), 0);
    pix(1'b1, 1'b0, 1'b1);
    chk("t4_no_sof_le", int'(line_en), 0);
    push_frame();
    send(LW * FH, 1'b0, -1, le, first, b2b);
    idle(3);
    chk("t4_wins", win_cnt - w0, 35);
    chk("t4_eofs", eof_cnt - e0, 1);
    chk("t4_sb_empty", sb.size(), 0);

    // sof at pixel (4,2)
    w0 = win_cnt;
    e0 = eof_cnt;
    f0 = ferr_cnt;
`ifdef SOF_RESYNC_EN
    push_win(1, 1, 1'b0);
    push_win(2, 1, 1'b0);
    push_frame();
    send(24 + LW * FH, 1'b0, 24, le, first, b2b);
    idle(3);
    chk("t5_line_en", le, 74);
    chk("t5_ferr", ferr_cnt - f0, 1);
    chk("t5_wins", win_cnt - w0, 26);
`else
    push_frame();
    send(LW * FH, 1'b0, 24, le, first, b2b);
    idle(3);
    chk("t5_line_en", le, 50);
    chk("t5_ferr", ferr_cnt - f0, 0);
    chk("t5_wins", win_cnt - w0, 24);
`endif
    chk("t5_eofs", eof_cnt - e0, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // back-to-back frames; sof on the last pixel is dropped
    w0 = win_cnt;
    e0 = eof_cnt;
    push_frame();
    push_frame();
    send(LW * FH, 1'b0, -1, le, first, b2b);
    chk("t6_le_a", le, 50);
    send(LW * FH, 1'b0, LW * FH - 1, le, first, b2b);
    chk("t6_le_b", le, 50);
    pix(1'b1, 1'b0, 1'b1);
    chk("t6_drop_le", int'(line_en), 0);
    chk("t6_busy", int'(busy), 0);
    idle(3);
    chk("t6_wins", win_cnt - w0, 48);
    chk("t6_eofs", eof_cnt - e0, 2);
    chk("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
